// File: rtl/qspi_tx.sv
// Quad-SPI transmit engine: packs queued 2-bit symbols into nibbles and frames
// command, address and data phases onto the QSPI pins (mode 0).
module qspi_tx #(
    parameter int unsigned DEPTH = 24
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        clear,
    input  logic        push,
    input  logic [1:0]  push_data,
    output logic        full,
    output logic        empty,
    output logic [6:0]  count,
    input  logic        start,
    input  logic [7:0]  cmd,
    input  logic [23:0] addr,
    input  logic [7:0]  len,
    output logic        busy,
    output logic        done,
    output logic        underrun,
    output logic        sclk,
    output logic        cs_n,
    output logic [3:0]  io_out,
    output logic [3:0]  io_oe
);

    localparam int unsigned PtrW = $clog2(DEPTH);

    typedef enum logic [2:0] {StIdle, StCmd, StAddr, StData, StStall, StEnd} state_e;

    state_e          state_q, state_d;
    logic            phase_q, phase_d;
    logic [2:0]      hdr_q, hdr_d;
    logic [27:0]     sh_q, sh_d;
    logic [7:0]      left_q, left_d;
    logic [3:0]      io_q, io_d;
    logic [6:0]      count_q, count_d;
    logic [PtrW-1:0] wr_q, rd_q;
    logic [1:0]      mem [DEPTH];

    logic sclk_q, cs_n_q, done_q, und_q, busy_q, full_q, empty_q;
    logic [3:0] oe_q;

    logic       push_ok, have_pair, boundary, take, pop, active_d, cs_n_d;
    logic [3:0] nibble;

    assign push_ok   = push && (count_q != 7'(DEPTH)) && !clear;
    assign have_pair = count_q >= 7'd2;
    // rd_q is always even, so its pair partner never wraps
    assign nibble    = {mem[rd_q], mem[rd_q | PtrW'(1)]};

    always_comb begin
        state_d  = state_q;
        phase_d  = phase_q;
        hdr_d    = hdr_q;
        sh_d     = sh_q;
        left_d   = left_q;
        io_d     = io_q;
        boundary = 1'b0;
        take     = 1'b0;
        pop      = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (start) begin
                    state_d = StCmd;
                    phase_d = 1'b0;
                    hdr_d   = 3'd0;
                    io_d    = cmd[7:4];
                    sh_d    = {cmd[3:0], addr};
                    left_d  = len;
                end
            end
            StCmd, StAddr: begin
                if (!phase_q) begin
                    phase_d = 1'b1;
                end else if (hdr_q == 3'd7) begin
                    boundary = 1'b1;
                end else begin
                    hdr_d   = hdr_q + 3'd1;
                    io_d    = sh_q[27:24];
                    sh_d    = {sh_q[23:0], 4'h0};
                    phase_d = 1'b0;
                    state_d = (hdr_q == 3'd0) ? StCmd : StAddr;
                end
            end
            StData: begin
                if (!phase_q) phase_d = 1'b1;
                else          boundary = 1'b1;
            end
            StStall: begin
                if (have_pair) take = 1'b1;
            end
            StEnd: begin
                state_d = StIdle;
                phase_d = 1'b0;
            end
            default: state_d = StIdle;
        endcase

        if (boundary) begin
            phase_d = 1'b0;
            if (left_q == 8'd0)  state_d = StEnd;
            else if (have_pair)  take = 1'b1;
            else                 state_d = StStall;
        end

        if (take) begin
            pop     = 1'b1;
            io_d    = nibble;
            left_d  = left_q - 8'd1;
            state_d = StData;
            phase_d = 1'b0;
        end

        if (clear) begin
            state_d = StIdle;
            phase_d = 1'b0;
            pop     = 1'b0;
        end

        count_d  = clear ? 7'd0
                         : count_q + {6'd0, push_ok} - (pop ? 7'd2 : 7'd0);
        active_d = (state_d == StCmd) || (state_d == StAddr) || (state_d == StData);
        cs_n_d   = !(active_d || state_d == StStall);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= StIdle;
            phase_q <= 1'b0;
            hdr_q   <= 3'd0;
            sh_q    <= '0;
            left_q  <= '0;
            io_q    <= '0;
            count_q <= '0;
            wr_q    <= '0;
            rd_q    <= '0;
            sclk_q  <= 1'b0;
            cs_n_q  <= 1'b1;
            oe_q    <= 4'h0;
            done_q  <= 1'b0;
            und_q   <= 1'b0;
            busy_q  <= 1'b0;
            full_q  <= 1'b0;
            empty_q <= 1'b1;
        end else begin
            state_q <= state_d;
            phase_q <= phase_d;
            hdr_q   <= hdr_d;
            sh_q    <= sh_d;
            left_q  <= left_d;
            io_q    <= io_d;
            count_q <= count_d;
            if (clear)        wr_q <= '0;
            else if (push_ok) wr_q <= (wr_q == PtrW'(DEPTH - 1)) ? '0 : wr_q + PtrW'(1);
            if (clear)        rd_q <= '0;
            else if (pop)     rd_q <= (rd_q == PtrW'(DEPTH - 2)) ? '0 : rd_q + PtrW'(2);
            sclk_q  <= phase_d && active_d;
            cs_n_q  <= cs_n_d;
            oe_q    <= cs_n_d ? 4'h0 : 4'hF;
            done_q  <= (state_d == StEnd);
            und_q   <= (state_d == StStall) && (state_q != StStall);
            busy_q  <= (state_d != StIdle);
            full_q  <= (count_d == 7'(DEPTH));
            empty_q <= (count_d == 7'd0);
        end
    end

    always_ff @(posedge clk) begin
        if (rst_n && push_ok) mem[wr_q] <= push_data;
    end

    assign full     = full_q;
    assign empty    = empty_q;
    assign count    = count_q;
    assign busy     = busy_q;
    assign done     = done_q;
    assign underrun = und_q;
    assign sclk     = sclk_q;
    assign cs_n     = cs_n_q;
    assign io_out   = io_q;
    assign io_oe    = oe_q;

endmodule

// File: doc/qspi_tx.md
# qspi_tx

Transmit-side QSPI engine, the outbound counterpart of the receive FIFO that unpacks flash nibbles into 2-bit symbols.
- Game logic pushes 2-bit symbols into an internal FIFO.
- On `start`, the block frames a quad-mode transaction on the QSPI pins: 8-bit command, 24-bit address, then `len` data nibbles drawn from the FIFO.
- Sits between the symbol producer and the QSPI pad ring; used for PSRAM writes.

## Interface

Parameters:
- DEPTH, 24, FIFO capacity in 2-bit symbols (even, ≤ 126).

Ports:
- clk  in  1  clock.
- rst_n  in  1  reset, synchronous, active-low.
- clear  in  1  flush FIFO and abort any frame.
- push  in  1  write `push_data` into FIFO.
- push_data  in  2  symbol.
- full  out  1  count == DEPTH.
- empty  out  1  count == 0.
- count  out  7  symbols held.
- start  in  1  begin frame; sampled only in IDLE.
- cmd  in  8  command byte, captured on accepted `start`.
- addr  in  24  address, captured on accepted `start`.
- len  in  8  data nibbles in frame, captured on accepted `start`.
- busy  out  1  state != IDLE.
- done  out  1  one-cycle pulse at frame end.
- underrun  out  1  one-cycle pulse on entering STALL.
- sclk  out  1  QSPI clock, mode 0.
- cs_n  out  1  chip select, active low.
- io_out  out  4  QSPI data out.
- io_oe  out  4  output enable, 4'hF while cs_n == 0, else 4'h0.

## Operation

- Packing and FIFO:
  - Oldest symbol is the nibble's high half: nibble = {first, second}.
  - A nibble needs count ≥ 2 and pops 2 symbols.
  - A push when `full` is dropped, even if a pop happens in the same cycle.
  - Push and pop in the same cycle: count ← count + 1 − 2.
- Nibble order: cmd[7:4], cmd[3:0], addr[23:20] … addr[3:0], then data nibbles.
- States:
  - IDLE: `start` → CMD.
  - CMD: 2 nibbles, then → ADDR.
  - ADDR: 6 nibbles, then → DATA if len ≠ 0, else → END.
  - DATA: `len` nibbles, then → END.
  - STALL: entered from DATA at a nibble boundary when count < 2; returns to DATA when count ≥ 2.
  - END: 1 cycle, then → IDLE.
- Each nibble takes 2 cycles:
  - Phase 0: load `io_out`, sclk = 0.
  - Phase 1: sclk = 1; the slave samples on this rising edge.
- A data nibble pops at the clock edge entering its phase 0, using the pre-edge count.
- STALL: sclk = 0, cs_n = 0, io_out holds the last nibble; `underrun` pulses on entry only.
- END: cs_n = 1, io_oe = 0, sclk = 0, done = 1.
- clear:
  - Next cycle: count = 0, state IDLE, cs_n = 1, io_oe = 0, sclk = 0.
  - No `done` pulse; has priority over push/start.
- Reset (also mid-frame): same as clear; additionally io_out = 0, done = 0, underrun = 0, busy = 0, empty = 1, full = 0.
- `start` while busy is ignored; cmd/addr/len may change freely after capture.

## Timing

- All outputs are registered.
- Frame timing, with `start` accepted at edge cycle 0 and N = 8 + len (no stall):
  - Nibble k (0-based) is on io_out in cycles 2k+1 and 2k+2.
  - sclk is high in cycle 2k+2.
  - cs_n is low in cycles 1 through 2N.
  - END (done = 1, cs_n = 1) is in cycle 2N+1.
  - busy is high in cycles 1 through 2N+1.
  - A new `start` can be accepted in cycle 2N+2.
- Each stall cycle delays all later events by 1 cycle.
- A symbol pushed in cycle t counts toward the boundary check at the edge ending cycle t+1. Resume from STALL takes effect at the first edge where pre-edge count ≥ 2.
- FIFO latency: a push in cycle t is visible on `count` in cycle t+1.

## Test plan

- Address-only frame: len = 0, cmd = 0x38, addr = 0x123456, start at cycle 0.
  - io_out = 3,8,1,2,3,4,5,6.
  - 8 sclk pulses, cs_n low in cycles 1–16.
  - done in cycle 17; FIFO untouched.
- Data frame: push 2'b10, 2'b01, 2'b11, 2'b00, then start with len = 2.
  - Data nibbles 0x9, 0xC.
  - count 4 → 2 → 0; done in cycle 21; empty = 1 after.
- Underrun: len = 2 with only 2 symbols queued.
  - After nibble 8, enter STALL: underrun pulse, sclk held low, cs_n low.
  - Push 2 symbols: frame resumes, and done arrives 1 cycle per stall cycle late.
- FIFO full: push 26 symbols with DEPTH = 24.
  - count saturates at 24, full = 1, last 2 pushes dropped.
  - Push + pop at full: push dropped, count 22.
- Clear mid-frame: assert clear in ADDR.
  - Next cycle: cs_n = 1, io_oe = 0, busy = 0, count = 0, no done.
  - A subsequent start runs a normal frame.
- Reset mid-data: rst_n low during DATA.
  - All outputs at reset values the next cycle.
  - start during reset is ignored.
